// File: rtl/byte_serial_addsub.sv
// Byte-serial add/subtract: one 8-bit carry-lookahead slice is reused for each
// operand byte, LSB first, so a full-width result costs N_BYTES clocks.
module byte_serial_addsub #(
  parameter int N_BYTES = 4,
  localparam int W = 8 * N_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic [1:0]   dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic         c_r;
  logic [2:0]   idx;
  logic [W-1:0] res_r;
  logic         cout_r;
  logic         ovf_r;
  logic         zero_r;

  logic [7:0]   a_byte;
  logic [7:0]   b_byte;
  logic [7:0]   slice_s;
  logic         slice_co;
  logic [W-1:0] res_nxt;
  logic         last_byte;

  // Sum-of-products carry lookahead: each carry is a flat OR of generate terms
  // gated by the propagate chain, with no ripple between bit positions.
  function automatic logic [8:0] cla8(input logic [7:0] x, input logic [7:0] y,
                                      input logic ci);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       pp;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & ci);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  always_comb begin
    a_byte = '0;
    b_byte = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      if (idx == 3'(k)) begin
        a_byte = a_r[8*k +: 8];
        b_byte = b_r[8*k +: 8];
      end
    end
  end

  assign {slice_co, slice_s} = cla8(a_byte, b_byte, c_r);

  // Assembled result including the byte being produced this cycle, so the
  // zero flag can be registered on the final byte without an extra cycle.
  always_comb begin
    res_nxt = res_r;
    for (int k = 0; k < N_BYTES; k++) begin
      if (idx == 3'(k)) res_nxt[8*k +: 8] = slice_s;
    end
  end

  assign last_byte = (idx == 3'(N_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      c_r    <= 1'b0;
      idx    <= '0;
      res_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b ^ {W{sub}};
            c_r   <= sub;
            idx   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          res_r <= res_nxt;
          c_r   <= slice_co;
          idx   <= idx + 3'd1;
          if (last_byte) begin
            cout_r <= slice_co;
            ovf_r  <= (a_r[W-1] == b_r[W-1]) && (slice_s[7] != a_r[W-1]);
            zero_r <= (res_nxt == '0);
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: a transfer happens on an edge where valid && ready; both ready
  // and valid outputs are pure state decodes with no path from the peer.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = res_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_byte_serial_addsub.sv
// Bench for byte_serial_addsub at 4, 1 and 8 bytes, checked against a plain
// arithmetic reference model through a result queue.
module tb_byte_serial_addsub;

  logic        clk;
  logic        rst_n;
  logic        drv_valid;
  logic        drv_ready;
  logic        drv_sub;
  logic [63:0] drv_a;
  logic [63:0] drv_b;
  int          sel;

  logic        ir4, ov4, c4, o4, z4;
  logic [31:0] s4;
  logic [1:0]  d4;
  logic        ir1, ov1, c1, o1, z1;
  logic [7:0]  s1;
  logic [1:0]  d1;
  logic        ir8, ov8, c8, o8, z8;
  logic [63:0] s8;
  logic [1:0]  d8;

  logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_zero;
  logic [63:0] m_sum;
  logic [1:0]  m_dbg;

  int n_assert;
  int n_fail;
  logic [66:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  byte_serial_addsub #(.N_BYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 0), .in_ready(ir4),
    .a(drv_a[31:0]), .b(drv_b[31:0]), .sub(drv_sub), .out_valid(ov4),
    .out_ready(drv_ready && sel == 0), .sum(s4), .cout(c4), .ovf(o4), .zero(z4),
    .dbg_state(d4));

  byte_serial_addsub #(.N_BYTES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 1), .in_ready(ir1),
    .a(drv_a[7:0]), .b(drv_b[7:0]), .sub(drv_sub), .out_valid(ov1),
    .out_ready(drv_ready && sel == 1), .sum(s1), .cout(c1), .ovf(o1), .zero(z1),
    .dbg_state(d1));

  byte_serial_addsub #(.N_BYTES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 2), .in_ready(ir8),
    .a(drv_a), .b(drv_b), .sub(drv_sub), .out_valid(ov8),
    .out_ready(drv_ready && sel == 2), .sum(s8), .cout(c8), .ovf(o8), .zero(z8),
    .dbg_state(d8));

  assign m_in_ready  = (sel == 0) ? ir4 : (sel == 1) ? ir1 : ir8;
  assign m_out_valid = (sel == 0) ? ov4 : (sel == 1) ? ov1 : ov8;
  assign m_cout      = (sel == 0) ? c4  : (sel == 1) ? c1  : c8;
  assign m_ovf       = (sel == 0) ? o4  : (sel == 1) ? o1  : o8;
  assign m_zero      = (sel == 0) ? z4  : (sel == 1) ? z1  : z8;
  assign m_sum       = (sel == 0) ? 64'(s4) : (sel == 1) ? 64'(s1) : s8;
  assign m_dbg       = (sel == 0) ? d4  : (sel == 1) ? d1  : d8;

  function automatic int nbytes(input int s);
    case (s)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  // Reference: W-bit unsigned arithmetic for sum/carry, sign rules for overflow.
  function automatic logic [66:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                        input logic s, input int w);
    logic [63:0] mask, a, b, r;
    logic [64:0] full;
    logic        c, o, sa, sb, sr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    if (!s) begin
      full = {1'b0, a} + {1'b0, b};
      c    = full[w];
      r    = full[63:0] & mask;
    end else begin
      r = (a - b) & mask;
      c = (a >= b);
    end
    sa = a[w-1];
    sb = b[w-1];
    sr = r[w-1];
    o  = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    return {c, o, (r == 64'd0), r};
  endfunction

  task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                        input int stall, input bit noise, input bit pre_ready,
                        output logic [66:0] got);
    int          n, guard, lat;
    logic [66:0] snap, exp;
    logic [1:0]  dbg_done;
    n         = nbytes(sel);
    drv_a     = a;
    drv_b     = b;
    drv_sub   = s;
    drv_valid = 1'b1;
    guard     = 0;
    while (!m_in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 67'(guard < 50), 67'd1);
    @(posedge clk); #1;
    exp_q.push_back(model(a, b, s, 8 * n));
    drv_valid = noise;
    drv_ready = pre_ready;
    lat = 0;
    while (!m_out_valid && lat < 20) begin
      check("in_ready_run", 67'(m_in_ready), 67'd0);
      if (noise) begin
        drv_a   = {$urandom, $urandom};
        drv_b   = {$urandom, $urandom};
        drv_sub = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 67'(lat), 67'(n));
    snap     = {m_cout, m_ovf, m_zero, m_sum};
    dbg_done = m_dbg;
    if (!pre_ready) begin
      repeat (stall) begin
        @(posedge clk); #1;
        check("hold_result", {m_cout, m_ovf, m_zero, m_sum}, snap);
        check("out_valid_hold", 67'(m_out_valid), 67'd1);
        check("in_ready_done", 67'(m_in_ready), 67'd0);
      end
    end
    exp = exp_q.pop_front();
    check("sum", 67'(snap[63:0]), 67'(exp[63:0]));
    check("cout", 67'(snap[66]), 67'(exp[66]));
    check("ovf", 67'(snap[65]), 67'(exp[65]));
    check("zero", 67'(snap[64]), 67'(exp[64]));
    drv_ready = 1'b1;
    @(posedge clk); #1;
    drv_ready = 1'b0;
    drv_valid = 1'b0;
    check("out_valid_fall", 67'(m_out_valid), 67'd0);
    check("in_ready_rise", 67'(m_in_ready), 67'd1);
    check("dbg_state_leaves_done", 67'(dbg_done != m_dbg), 67'd1);
    got = snap;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d_a[6], d_b[6], d_sum[6];
    logic        d_s[6], d_c[6], d_o[6], d_z[6];
    logic [66:0] got;
    logic [63:0] ra, rb;

    d_a   = '{32'h0000_00FF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd5,         32'h8000_0000, 32'h0000_1234};
    d_b   = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7,         32'h0000_0001, 32'h0000_1234};
    d_s   = '{1'b0,          1'b0,          1'b0,          1'b1,          1'b1,          1'b1};
    d_sum = '{32'h0000_0100, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_0000};
    d_c   = '{1'b0,          1'b1,          1'b0,          1'b0,          1'b1,          1'b1};
    d_o   = '{1'b0,          1'b0,          1'b1,          1'b0,          1'b1,          1'b0};
    d_z   = '{1'b0,          1'b1,          1'b0,          1'b0,          1'b0,          1'b1};

    n_assert  = 0;
    n_fail    = 0;
    sel       = 0;
    rst_n     = 1'b0;
    drv_valid = 1'b0;
    drv_ready = 1'b0;
    drv_sub   = 1'b0;
    drv_a     = '0;
    drv_b     = '0;
    #23 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      check("reset_in_ready", 67'(m_in_ready), 67'd1);
      check("reset_out_valid", 67'(m_out_valid), 67'd0);
      check("reset_outputs", {m_cout, m_ovf, m_zero, m_sum}, 67'd0);
    end

    // Directed arithmetic corners on the 4-byte unit.
    sel = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(64'(d_a[i]), 64'(d_b[i]), d_s[i], 1, 1'b0, 1'b0, got);
      check("dir_sum", 67'(got[31:0]), 67'(d_sum[i]));
      check("dir_flags", 67'(got[66:64]), 67'({d_c[i], d_o[i], d_z[i]}));
    end

    // Backpressure with operands presented during RUN and DONE.
    run_op(64'h1111_1111, 64'h2222_2222, 1'b0, 3, 1'b1, 1'b0, got);
    check("bp_sum", 67'(got[31:0]), 67'h3333_3333);
    run_op(64'h0000_0009, 64'h0000_0004, 1'b1, 0, 1'b0, 1'b0, got);
    check("bp_next_sum", 67'(got[31:0]), 67'h0000_0005);

    // Asynchronous reset two bytes into an operation.
    drv_a = 64'h0F0F_0F0F; drv_b = 64'h1010_1010; drv_sub = 1'b0; drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 67'(m_out_valid), 67'd0);
    check("midreset_in_ready", 67'(m_in_ready), 67'd1);
    check("midreset_outputs", {m_cout, m_ovf, m_zero, m_sum}, 67'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(64'h0101_0101, 64'h0202_0202, 1'b0, 0, 1'b0, 1'b0, got);
    check("post_reset_sum", 67'(got[31:0]), 67'h0303_0303);

    // Random operands, stalls and early out_ready on every width.
    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
        run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
